// File: rtl/scaled_fb_fetch.sv
// Frame-buffer prefetcher: reads source pixels, replicates them 2^HSCALE_LOG2 x 2^VSCALE_LOG2 into the pixel FIFO.
// Optional FB_FETCH_FRAME_SYNC_EN adds a frame_sync input that gates the start of every frame.
module scaled_fb_fetch #(
    parameter int                DATA_W      = 24,
    parameter int                ADDR_W      = 24,
    parameter int                SRC_W       = 80,
    parameter int                SRC_H       = 60,
    parameter int                HSCALE_LOG2 = 3,
    parameter int                VSCALE_LOG2 = 3,
    parameter logic [ADDR_W-1:0] FRAME_BASE  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              fifo_sof,
    output logic              fifo_eol
`ifdef FB_FETCH_FRAME_SYNC_EN
    ,
    input  logic              frame_sync
`endif
);

    localparam int XW = $clog2(SRC_W);
    localparam int YW = $clog2(SRC_H);
    localparam logic [XW-1:0]     X_LAST      = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     Y_LAST      = YW'(SRC_H - 1);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(SRC_W);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, EMIT} state_t;

    state_t                  state, state_next;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [HSCALE_LOG2-1:0]  h_rep;
    logic [VSCALE_LOG2-1:0]  v_rep;
    logic [ADDR_W-1:0]       line_start;

    logic start, wrap;
    logic x_last, y_last, h_last, v_last, frame_last;

`ifdef FB_FETCH_FRAME_SYNC_EN
    assign start = en & frame_sync;
    assign wrap  = 1'b0;
`else
    assign start = en;
    assign wrap  = en;
`endif

    assign x_last     = (x == X_LAST);
    assign y_last     = (y == Y_LAST);
    assign h_last     = &h_rep;
    assign v_last     = &v_rep;
    assign frame_last = x_last & v_last & y_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output is given a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        fifo_wr    = 1'b0;
        fifo_sof   = 1'b0;
        fifo_eol   = 1'b0;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: state_next = LATCH;
            LATCH: state_next = EMIT;
            EMIT: begin
                fifo_wr = ~fifo_full;
                if (fifo_wr && h_last) begin
                    if (frame_last) state_next = wrap ? FETCH : IDLE;
                    else            state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
        fifo_sof = fifo_wr && x == '0 && y == '0 && v_rep == '0 && h_rep == '0;
        fifo_eol = fifo_wr && x_last && h_last;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd     <= 1'b0;
            mem_addr   <= FRAME_BASE;
            line_start <= FRAME_BASE;
            fifo_wdata <= '0;
            x          <= '0;
            y          <= '0;
            h_rep      <= '0;
            v_rep      <= '0;
        end else begin
            // Registered strobe that is high exactly while the FSM sits in FETCH.
            mem_rd <= (state_next == FETCH);

            if (state == LATCH) fifo_wdata <= mem_rdata;

            if (fifo_wr) begin
                h_rep <= h_rep + HSCALE_LOG2'(1);
                if (h_last) begin
                    if (!x_last) begin
                        x        <= x + XW'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end else begin
                        x <= '0;
                        if (!v_last) begin
                            v_rep    <= v_rep + VSCALE_LOG2'(1);
                            mem_addr <= line_start;
                        end else begin
                            v_rep <= '0;
                            if (y_last) begin
                                y          <= '0;
                                line_start <= FRAME_BASE;
                                mem_addr   <= FRAME_BASE;
                            end else begin
                                y          <= y + YW'(1);
                                line_start <= line_start + LINE_STRIDE;
                                mem_addr   <= line_start + LINE_STRIDE;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scaled_fb_fetch.sv
// Self-checking bench for scaled_fb_fetch: 4x2 source, 2x2 replication, frame base 0x10, memory word = address.
module tb_scaled_fb_fetch;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int HS  = 2;
    localparam int VS  = 2;
    localparam int WPF = W * HS * H * VS;  // writes per frame
    localparam int RPF = W * H * VS;       // reads per frame
    localparam logic [AW-1:0] BASE = 16'h0010;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          fifo_full = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          fifo_wr;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_sof;
    logic          fifo_eol;
`ifdef FB_FETCH_FRAME_SYNC_EN
    logic          frame_sync = 1'b1;
`endif

    scaled_fb_fetch #(
        .DATA_W(DW), .ADDR_W(AW), .SRC_W(W), .SRC_H(H),
        .HSCALE_LOG2(1), .VSCALE_LOG2(1), .FRAME_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .fifo_sof(fifo_sof), .fifo_eol(fifo_eol)
`ifdef FB_FETCH_FRAME_SYNC_EN
        , .frame_sync(frame_sync)
`endif
    );

    always #5 clk = ~clk;

    // Memory returns its own address, one cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
    } wr_t;

    wr_t           wr_q[$];
    int            wr_cyc[$];
    logic [AW-1:0] rd_q[$];
    int            rd_cyc[$];
    int            cyc = 0;
    int            wr_while_full = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor samples 2 time units after the falling edge, once inputs are settled.
    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        if (fifo_wr) begin
            wr_q.push_back('{data: fifo_wdata, sof: fifo_sof, eol: fifo_eol});
            wr_cyc.push_back(cyc);
            if (fifo_full) wr_while_full++;
        end
        if (mem_rd) begin
            rd_q.push_back(mem_addr);
            rd_cyc.push_back(cyc);
        end
    end

    function automatic wr_t exp_wr(input int i);
        int j = i % WPF;
        int h = j % HS;
        int x = (j / HS) % W;
        int v = (j / (HS * W)) % VS;
        int y = j / (HS * W * VS);
        wr_t r;
        r.data = DW'(int'(BASE) + y * W + x);
        r.sof  = (j == 0);
        r.eol  = (x == W - 1) && (h == HS - 1);
        if (v < 0) r.sof = 1'b0;
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_rd(input int i);
        int j = i % RPF;
        return AW'(int'(BASE) + (j / (W * VS)) * W + (j % W));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Enables the DUT at a falling edge; this cycle becomes cycle 0 for the monitor.
    task automatic start_run();
        @(negedge clk);
        wr_q.delete(); wr_cyc.delete(); rd_q.delete(); rd_cyc.delete();
        wr_while_full = 0;
        cyc = -1;
        en = 1'b1;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_q.size() < n && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        check({tag, "_wait"}, 64'(wr_q.size() >= n), 64'd1);
    endtask

    task automatic cmp_stream(input string tag, input int nw, input int nr);
        for (int i = 0; i < nw; i++) begin
            wr_t e = exp_wr(i);
            wr_t a = '{data: 'x, sof: 'x, eol: 'x};
            if (i < wr_q.size()) a = wr_q[i];
            check($sformatf("%s_wr%0d{data,sof,eol}", tag, i), {a.data, a.sof, a.eol}, {e.data, e.sof, e.eol});
        end
        for (int i = 0; i < nr; i++) begin
            logic [AW-1:0] a = 'x;
            if (i < rd_q.size()) a = rd_q[i];
            check($sformatf("%s_rd%0d_addr", tag, i), a, exp_rd(i));
        end
    endtask

    typedef struct {
        logic          en;
        logic          full;
        logic          mem_rd;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic          sof;
        logic          eol;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Start-up cycles from IDLE, including a two-cycle stall on the second copy of pixel 0.
        vecs[0]  = '{1, 0, 0, 16'h10, 0, 16'h00, 0, 0};  // IDLE
        vecs[1]  = '{1, 0, 1, 16'h10, 0, 16'h00, 0, 0};  // FETCH px0
        vecs[2]  = '{1, 0, 0, 16'h10, 0, 16'h00, 0, 0};  // LATCH
        vecs[3]  = '{1, 0, 0, 16'h10, 1, 16'h10, 1, 0};  // EMIT h0, sof
        vecs[4]  = '{1, 1, 0, 16'h10, 0, 16'h10, 0, 0};  // stalled
        vecs[5]  = '{1, 1, 0, 16'h10, 0, 16'h10, 0, 0};  // stalled
        vecs[6]  = '{1, 0, 0, 16'h10, 1, 16'h10, 0, 0};  // EMIT h1
        vecs[7]  = '{1, 0, 1, 16'h11, 0, 16'h10, 0, 0};  // FETCH px1
        vecs[8]  = '{1, 0, 0, 16'h11, 0, 16'h10, 0, 0};  // LATCH
        vecs[9]  = '{1, 0, 0, 16'h11, 1, 16'h11, 0, 0};  // EMIT h0
        vecs[10] = '{1, 0, 0, 16'h11, 1, 16'h11, 0, 0};  // EMIT h1
        vecs[11] = '{1, 0, 1, 16'h12, 0, 16'h11, 0, 0};  // FETCH px2

        // Reset state while rst is held.
        @(negedge clk);
        #1;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_wdata", fifo_wdata, 0);
        check("rst_fifo_sof", fifo_sof, 0);
        check("rst_fifo_eol", fifo_eol, 0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            en = vecs[i].en;
            fifo_full = vecs[i].full;
            #1;
            check($sformatf("vec%0d{mem_rd,addr,wr,wdata,sof,eol}", i),
                  {mem_rd, mem_addr, fifo_wr, fifo_wdata, fifo_sof, fifo_eol},
                  {vecs[i].mem_rd, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].sof, vecs[i].eol});
        end

`ifndef FB_FETCH_FRAME_SYNC_EN
        // Two back-to-back frames with no idle cycle between them.
        do_reset();
        start_run();
        wait_writes("b2b", 2 * WPF, 400);
        cmp_stream("b2b", 2 * WPF, 2 * RPF);
        check("b2b_first_rd_cycle", 64'(rd_cyc.size() > 0 ? rd_cyc[0] : -1), 64'd1);
        check("b2b_first_wr_cycle", 64'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 64'd3);
        check("b2b_frame_span", 64'(wr_cyc.size() >= WPF ? wr_cyc[WPF-1] - wr_cyc[0] : -1), 64'd61);
        check("b2b_no_idle_gap", 64'(rd_cyc.size() > RPF && wr_cyc.size() >= WPF ? rd_cyc[RPF] - wr_cyc[WPF-1] : -1), 64'd1);
`else
        // Frame sync gating: wait in IDLE until the pulse, read the next cycle, wait again after the frame.
        begin
            int m;
            do_reset();
            @(negedge clk);
            frame_sync = 1'b0;
            start_run();
            repeat (6) @(negedge clk);
            #3;
            check("fs_wait_no_rd", 64'(rd_q.size()), 64'd0);
            m = cyc;
            @(negedge clk);
            frame_sync = 1'b1;
            @(negedge clk);
            frame_sync = 1'b0;
            wait_writes("fs", WPF, 400);
            repeat (12) @(negedge clk);
            #3;
            check("fs_first_rd_cycle", 64'(rd_cyc.size() > 0 ? rd_cyc[0] : -1), 64'(m + 2));
            check("fs_reads_one_frame", 64'(rd_q.size()), 64'(RPF));
            check("fs_writes_one_frame", 64'(wr_q.size()), 64'(WPF));
            cmp_stream("fs", WPF, RPF);
            frame_sync = 1'b1;
        end
`endif

        // Five-cycle stall on the second copy of pixel 1.
        do_reset();
        start_run();
        repeat (8) @(negedge clk);
        fifo_full = 1'b1;
        repeat (5) @(negedge clk);
        fifo_full = 1'b0;
        wait_writes("stall", WPF, 400);
        cmp_stream("stall", WPF, RPF);
        check("stall_frame_span", 64'(wr_cyc.size() >= WPF ? wr_cyc[WPF-1] - wr_cyc[0] : -1), 64'd66);
        check("stall_wr_while_full", 64'(wr_while_full), 64'd0);

        // en dropped at output pixel 3: frame completes, then the block stays idle.
        do_reset();
        start_run();
        repeat (8) @(negedge clk);
        en = 1'b0;
        wait_writes("endrop", WPF, 400);
        repeat (20) @(negedge clk);
        #3;
        check("endrop_writes", 64'(wr_q.size()), 64'(WPF));
        check("endrop_reads", 64'(rd_q.size()), 64'(RPF));
        check("endrop_idle_mem_rd", mem_rd, 0);
        check("endrop_idle_addr", mem_addr, BASE);
        cmp_stream("endrop", WPF, RPF);

        // Reset in EMIT: immediate return to reset values, restart reproduces frame 0.
        do_reset();
        start_run();
        repeat (7) @(negedge clk);
        #1;
        check("rstemit_pre_wr", fifo_wr, 1);
        rst = 1'b1;
        #1;
        check("rstemit_addr", mem_addr, BASE);
        check("rstemit_wr", fifo_wr, 0);
        check("rstemit_mem_rd", mem_rd, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        start_run();
        wait_writes("restart", WPF, 400);
        cmp_stream("restart", WPF, RPF);
        check("restart_first_wr_cycle", 64'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
